// File: rtl/ram_pkg.sv
// Shared types and helpers for the ram_sdp_pipelined RAM family.
package ram_pkg;

   typedef enum logic {RAM_CLEAR, RAM_READY} ram_state_t;

   localparam int unsigned RD_LATENCY_MAX  = 4;
   localparam int unsigned PARITY_DATA_MAX = 1024;

   // Even-parity bit of one byte lane; callers widen their word with a size cast.
   function automatic logic byte_parity(input logic [PARITY_DATA_MAX-1:0] data,
                                        input int unsigned lane,
                                        input int unsigned byte_width = 8);
      logic [PARITY_DATA_MAX-1:0] mask;
      mask = (PARITY_DATA_MAX'(1) << byte_width) - PARITY_DATA_MAX'(1);
      return ^((data >> (lane * byte_width)) & mask);
   endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Valid+data delay line of parameterised depth with synchronous clear.
// Data registers load only with valid, so the output holds its last valid word.
module ram_rd_pipe #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 1
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   if (DEPTH == 0) begin : g_pass
      assign out_valid = in_valid;
      assign out_data  = in_data;
   end else begin : g_stages
      logic             valid_q [DEPTH];
      logic             valid_d [DEPTH];
      logic [WIDTH-1:0] data_q  [DEPTH];
      logic [WIDTH-1:0] data_d  [DEPTH];
      logic             valid_c [DEPTH+1];
      logic [WIDTH-1:0] data_c  [DEPTH+1];

      always_comb begin
         valid_c[0] = in_valid;
         data_c[0]  = in_data;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            valid_c[i+1] = valid_q[i];
            data_c[i+1]  = data_q[i];
         end
         for (int unsigned i = 0; i < DEPTH; i++) begin
            valid_d[i] = valid_c[i];
            data_d[i]  = valid_c[i] ? data_c[i] : data_q[i];
         end
      end

      always_ff @(posedge clk) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (clr) begin
               valid_q[i] <= 1'b0;
               data_q[i]  <= '0;
            end else begin
               valid_q[i] <= valid_d[i];
               data_q[i]  <= data_d[i];
            end
         end
      end

      assign out_valid = valid_q[DEPTH-1];
      assign out_data  = data_q[DEPTH-1];
   end

endmodule

// File: rtl/ram_sdp_pipelined.sv
// Simple-dual-port RAM: byte-lane writes, pipelined reads, optional post-reset clear sweep.
// Define RAM_SDP_PARITY_EN for per-lane even parity with error injection and read-side checking.
module ram_sdp_pipelined
   import ram_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned BYTE_WIDTH     = 8,
   parameter int unsigned ADDR_WIDTH     = 10,
   parameter int unsigned RD_LATENCY     = 2,
   parameter int unsigned WRITE_FIRST    = 1,
   parameter int unsigned CLEAR_ON_RESET = 1,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
   localparam int unsigned NUM_BYTES     = DATA_WIDTH / BYTE_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  ready,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [NUM_BYTES-1:0]  wr_be
`ifdef RAM_SDP_PARITY_EN
   ,
   input  logic [NUM_BYTES-1:0]  wr_par_inv,
   output logic [NUM_BYTES-1:0]  rd_par_err
`endif
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
`ifdef RAM_SDP_PARITY_EN
   localparam int unsigned PIPE_W = DATA_WIDTH + NUM_BYTES;
`else
   localparam int unsigned PIPE_W = DATA_WIDTH;
`endif

   if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
      $fatal(1, "ram_sdp_pipelined: DATA_WIDTH must be a multiple of BYTE_WIDTH");
   end
   if (RD_LATENCY < 1 || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
      $fatal(1, "ram_sdp_pipelined: RD_LATENCY must be in 1..4");
   end

   ram_state_t            state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  ready_q, ready_d;
   logic                  wr_acc, rd_acc;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [NUM_BYTES-1:0]  mem_wmask;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic                  bypass;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [PIPE_W-1:0]     rd_entry;
   logic                  s1_valid_q, s1_valid_d;
   logic [PIPE_W-1:0]     s1_data_q, s1_data_d;
   logic                  pipe_valid;
   logic [PIPE_W-1:0]     pipe_data;

`ifdef RAM_SDP_PARITY_EN
   logic [NUM_BYTES-1:0]  par_q [DEPTH];
   logic [NUM_BYTES-1:0]  mem_wpar;
   logic [NUM_BYTES-1:0]  rd_perr;
`endif

   // Sweep and user writes share one array write port; the sweep owns it while clearing.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wr_acc    = ready_q & wr_en & ~rst;
      rd_acc    = ready_q & rd_en & ~rst;
      mem_we    = 1'b0;
      mem_waddr = wr_addr;
      mem_wdata = wr_data;
      mem_wmask = wr_be;
      unique case (state_q)
         RAM_CLEAR: begin
            mem_we    = ~rst;
            mem_waddr = cnt_q;
            mem_wdata = CLEAR_VALUE;
            mem_wmask = '1;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == '1) state_d = RAM_READY;
         end
         RAM_READY: mem_we = wr_acc;
         default:   state_d = RAM_READY;
      endcase
      ready_d = (state_d == RAM_READY);
`ifdef RAM_SDP_PARITY_EN
      mem_wpar = '0;
      for (int unsigned i = 0; i < NUM_BYTES; i++) begin
         mem_wpar[i] = byte_parity(PARITY_DATA_MAX'(mem_wdata), i, BYTE_WIDTH)
                     ^ ((state_q == RAM_READY) & wr_par_inv[i]);
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int unsigned i = 0; i < NUM_BYTES; i++) begin
            if (mem_wmask[i]) begin
               mem_q[mem_waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef RAM_SDP_PARITY_EN
               par_q[mem_waddr][i] <= mem_wpar[i];
`endif
            end
         end
      end
   end

   // Stage 1: array read with per-lane write-first bypass.
   always_comb begin
      rd_word = mem_q[rd_addr];
      bypass  = (WRITE_FIRST != 0) && wr_acc && (wr_addr == rd_addr);
`ifdef RAM_SDP_PARITY_EN
      rd_perr = '0;
`endif
      for (int unsigned i = 0; i < NUM_BYTES; i++) begin
`ifdef RAM_SDP_PARITY_EN
         rd_perr[i] = byte_parity(PARITY_DATA_MAX'(mem_q[rd_addr]), i, BYTE_WIDTH) ^ par_q[rd_addr][i];
`endif
         if (bypass && wr_be[i]) begin
            rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef RAM_SDP_PARITY_EN
            rd_perr[i] = wr_par_inv[i];
`endif
         end
      end
`ifdef RAM_SDP_PARITY_EN
      rd_entry = {rd_perr, rd_word};
`else
      rd_entry = rd_word;
`endif
      s1_valid_d = rd_acc;
      s1_data_d  = rd_acc ? rd_entry : s1_data_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= (CLEAR_ON_RESET != 0) ? RAM_CLEAR : RAM_READY;
         cnt_q      <= '0;
         ready_q    <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ready_q    <= ready_d;
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
      end
   end

   ram_rd_pipe #(
      .WIDTH (PIPE_W),
      .DEPTH (RD_LATENCY - 1)
   ) u_rd_pipe (
      .clk       (clk),
      .clr       (rst),
      .in_valid  (s1_valid_q),
      .in_data   (s1_data_q),
      .out_valid (pipe_valid),
      .out_data  (pipe_data)
   );

   assign ready    = ready_q;
   assign rd_valid = pipe_valid;
   assign rd_data  = pipe_data[DATA_WIDTH-1:0];
`ifdef RAM_SDP_PARITY_EN
   assign rd_par_err = pipe_valid ? pipe_data[PIPE_W-1 -: NUM_BYTES] : '0;
`endif

endmodule
